// File: rtl/pon_cfg_pkg.sv
// Shared types and constants for the PON datapath configuration commit path.
package pon_cfg_pkg;

    localparam int unsigned CFG_NUM_CH = 3;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned CFG_VEC_W  = CFG_NUM_CH * CFG_DATA_W;

    // Channel indices within the packed configuration vector
    localparam int unsigned CH_PRE_LEN = 0;
    localparam int unsigned CH_PRE_PAT = 1;
    localparam int unsigned CH_FRTRAIL = 2;

    localparam logic [CFG_DATA_W-1:0] DEF_PRE_LEN = 32'd64;
    localparam logic [CFG_DATA_W-1:0] DEF_PRE_PAT = 32'h5555_5555;
    localparam logic [CFG_DATA_W-1:0] DEF_FRTRAIL = 32'hA5A5_A5A5;

    localparam logic [CFG_VEC_W-1:0] DEF_CFG_VEC = {DEF_FRTRAIL, DEF_PRE_PAT, DEF_PRE_LEN};
    localparam logic [CFG_VEC_W-1:0] DEF_MIN_VEC = {32'h0000_0000, 32'h0000_0000, 32'd8};
    localparam logic [CFG_VEC_W-1:0] DEF_MAX_VEC = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd256};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PENDING = 2'd2,
        COMMIT  = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/pon_config_commit_stable_sync.sv
// Two-flop synchroniser feeding a candidate register with a saturating stability counter.
module cfg_stable_sync #(
    parameter int unsigned WIDTH         = 96,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] candidate,
    output logic             change_c,
    output logic             stable_c
);

    localparam int unsigned      CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_vec;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_vec  <= '0;
        end else begin
            sync_meta <= raw;
            sync_vec  <= sync_meta;
        end
    end

    assign change_c = (sync_vec != candidate);
    assign stable_c = (stable_cnt == CNT_MAX);

    // Any difference restarts the stability window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate  <= '0;
            stable_cnt <= '0;
        end else if (change_c) begin
            candidate  <= sync_vec;
            stable_cnt <= '0;
        end else if (stable_cnt != CNT_MAX) begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pon_config_commit.sv
// Filters, clamps and atomically commits VIO configuration words on a frame boundary.
module pon_config_commit
    import pon_cfg_pkg::*;
#(
    parameter int unsigned                  NUM_CH        = 3,
    parameter int unsigned                  DATA_W        = 32,
    parameter int unsigned                  STABLE_CYCLES = 8,
    parameter logic [NUM_CH*DATA_W-1:0]     DEFAULT_VEC   = DEF_CFG_VEC,
    parameter logic [NUM_CH*DATA_W-1:0]     MIN_VEC       = DEF_MIN_VEC,
    parameter logic [NUM_CH*DATA_W-1:0]     MAX_VEC       = DEF_MAX_VEC
) (
    input  logic                     hb0_gtwiz_userclk_tx_usrclk2_int,
    input  logic                     hb0_gtwiz_reset_all_n_int,
    input  logic [NUM_CH*DATA_W-1:0] cfg_raw_in,
    input  logic                     frame_boundary_in,
    input  logic                     commit_enable_in,
    output logic [NUM_CH*DATA_W-1:0] cfg_active_out,
    output logic                     cfg_pending_out,
    output logic                     cfg_update_pulse_out,
    output logic [NUM_CH-1:0]        cfg_clamped_out,
    output logic [15:0]              cfg_commit_cnt_out
);

    localparam int unsigned VEC_W = NUM_CH * DATA_W;

    logic clk;
    logic rst_n;
    assign clk   = hb0_gtwiz_userclk_tx_usrclk2_int;
    assign rst_n = hb0_gtwiz_reset_all_n_int;

    logic [VEC_W-1:0]  candidate;
    logic              change_c;
    logic              stable_c;
    logic [VEC_W-1:0]  cand_clamped;
    logic [NUM_CH-1:0] clamp_flags;
    logic              settle_match;
    logic [VEC_W-1:0]  shadow;
    logic [15:0]       commit_cnt;
    logic              upd_d;
    logic              chg_seen;

    cfg_state_e state;
    cfg_state_e state_nxt;

    logic accept;
    logic drop;
    logic do_commit;
    logic mark_chg;

    cfg_stable_sync #(
        .WIDTH         (VEC_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stable_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (cfg_raw_in),
        .candidate (candidate),
        .change_c  (change_c),
        .stable_c  (stable_c)
    );

    // Unsigned per-channel range clamp of the candidate
    always_comb begin
        cand_clamped = candidate;
        clamp_flags  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (candidate[k*DATA_W +: DATA_W] < MIN_VEC[k*DATA_W +: DATA_W]) begin
                cand_clamped[k*DATA_W +: DATA_W] = MIN_VEC[k*DATA_W +: DATA_W];
                clamp_flags[k]                   = 1'b1;
            end else if (candidate[k*DATA_W +: DATA_W] > MAX_VEC[k*DATA_W +: DATA_W]) begin
                cand_clamped[k*DATA_W +: DATA_W] = MAX_VEC[k*DATA_W +: DATA_W];
                clamp_flags[k]                   = 1'b1;
            end
        end
    end

    assign settle_match = (cand_clamped == cfg_active_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (change_c) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!change_c && stable_c) state_nxt = settle_match ? IDLE : PENDING;
            end
            PENDING: begin
                if (frame_boundary_in && commit_enable_in) state_nxt = COMMIT;
                else if (change_c)                         state_nxt = SETTLE;
            end
            COMMIT: begin
                state_nxt = (change_c || chg_seen) ? SETTLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        drop      = 1'b0;
        do_commit = 1'b0;
        mark_chg  = 1'b0;
        case (state)
            SETTLE:  accept    = !change_c && stable_c && !settle_match;
            PENDING: begin
                drop     = !(frame_boundary_in && commit_enable_in) && change_c;
                mark_chg = frame_boundary_in && commit_enable_in && change_c;
            end
            COMMIT:  do_commit = 1'b1;
            default: ;
        endcase
    end

    // Shadow/active registers; a change seen at the commit boundary is remembered for COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow               <= DEFAULT_VEC;
            cfg_active_out       <= DEFAULT_VEC;
            cfg_pending_out      <= 1'b0;
            cfg_clamped_out      <= '0;
            commit_cnt           <= '0;
            upd_d                <= 1'b0;
            cfg_update_pulse_out <= 1'b0;
            chg_seen             <= 1'b0;
        end else begin
            upd_d                <= do_commit;
            cfg_update_pulse_out <= upd_d;
            chg_seen             <= mark_chg;
            if (accept) begin
                shadow          <= cand_clamped;
                cfg_clamped_out <= clamp_flags;
                cfg_pending_out <= 1'b1;
            end else if (drop || do_commit) begin
                cfg_pending_out <= 1'b0;
            end
            if (do_commit) begin
                cfg_active_out <= shadow;
                commit_cnt     <= commit_cnt + 16'd1;
            end
        end
    end

    assign cfg_commit_cnt_out = commit_cnt;

endmodule
